// File: rtl/bcd_digit_feeder_pkg.sv
// Shared types and constants for the BCD digit feeder that sequences words
// into the combinational divisible-by-3 checker.
package bcd_feeder_pkg;

    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned WORD_DIGITS = 4;
    localparam int unsigned BCD_MAX     = 9;
    localparam int unsigned IDX_W       = 2;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EVAL    = 2'd1,
        ST_DONE    = 2'd2
    } feed_state_t;

    // Digits above 9 would push the sum outside the range the checker decodes.
    function automatic logic is_illegal(input logic [NIBBLE_W-1:0] nib);
        return nib > NIBBLE_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_feeder_if.sv
// Digit input handshake, checker nibble/verdict wiring and result handshake.
interface bcd_digit_feeder_if
    import bcd_feeder_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) ();

    logic                in_valid;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_nibble;
    logic [NIBBLE_W-1:0] a;
    logic [NIBBLE_W-1:0] b;
    logic [NIBBLE_W-1:0] c;
    logic [NIBBLE_W-1:0] d;
    logic                div_in;
    logic                res_valid;
    logic                res_ready;
    logic                res_div3;
    logic                res_err;
    logic [CNT_W-1:0]    match_count;

    modport slave (
        input  in_valid, in_nibble, div_in, res_ready,
        output in_ready, a, b, c, d, res_valid, res_div3, res_err, match_count
    );

    modport master (
        output in_valid, in_nibble, div_in, res_ready,
        input  in_ready, a, b, c, d, res_valid, res_div3, res_err, match_count
    );

endinterface

// File: rtl/bcd_digit_feeder.sv
// Collects four BCD digits into a word, presents it to the external checker,
// samples the verdict one cycle later and returns a registered result.
module bcd_digit_feeder
    import bcd_feeder_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    bcd_digit_feeder_if.slave  bus
);

    localparam logic [1:0] COLLECT = ST_COLLECT;
    localparam logic [1:0] EVAL    = ST_EVAL;
    localparam logic [1:0] DONE    = ST_DONE;

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                err_q, err_d;
    logic [NIBBLE_W-1:0] dig_q [WORD_DIGITS];
    logic [NIBBLE_W-1:0] dig_d [WORD_DIGITS];
    logic                res_div3_q, res_div3_d;
    logic                res_err_q, res_err_d;
    logic                res_valid_q, res_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            err_q       <= 1'b0;
            dig_q       <= '{default: '0};
            res_div3_q  <= 1'b0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            dig_q       <= dig_d;
            res_div3_q  <= res_div3_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        dig_d      = dig_q;
        res_div3_d = res_div3_q;
        res_err_d  = res_err_q;
        cnt_d      = cnt_q;
        hit        = 1'b0;

        case (state_q)
            COLLECT: begin
                if (bus.in_valid && in_ready_q) begin
                    dig_d[idx_q] = bus.in_nibble;
                    err_d        = err_q | is_illegal(bus.in_nibble);
                    idx_d        = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WORD_DIGITS - 1)) begin
                        state_d = EVAL;
                    end
                end
            end
            // Checker inputs have been stable for a full cycle here.
            EVAL: begin
                hit        = bus.div_in & ~err_q;
                res_div3_d = hit;
                res_err_d  = err_q;
                if (hit && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
                err_d   = 1'b0;
            end
        endcase

        // Handshake outputs are registered decodes of the next state.
        in_ready_d  = (state_d == COLLECT);
        res_valid_d = (state_d == DONE);
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_div3    = res_div3_q;
    assign bus.res_err     = res_err_q;
    assign bus.match_count = cnt_q;
    assign bus.a           = dig_q[0];
    assign bus.b           = dig_q[1];
    assign bus.c           = dig_q[2];
    assign bus.d           = dig_q[3];

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Self-checking bench: two feeders (CNT_W=8 and CNT_W=2) share stimulus and
// are scored against a word-level model of digit sums and saturating counts.
module tb_bcd_digit_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       res_ready = 1'b0;
    logic       force_div = 1'b0;
    logic [3:0] in_nibble = 4'd0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mdl_cnt8 = 0;
    int mdl_cnt2 = 0;
    int last_res_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_digit_feeder_if #(.CNT_W(8)) bus8 ();
    bcd_digit_feeder_if #(.CNT_W(2)) bus2 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_nibble = in_nibble;
    assign bus8.res_ready = res_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_nibble = in_nibble;
    assign bus2.res_ready = res_ready;

    // Behavioural stand-in for the sibling checker: digit sum mod 3.
    assign bus8.div_in = force_div | (((6'(bus8.a) + 6'(bus8.b) + 6'(bus8.c) + 6'(bus8.d)) % 6'd3) == 6'd0);
    assign bus2.div_in = force_div | (((6'(bus2.a) + 6'(bus2.b) + 6'(bus2.c) + 6'(bus2.d)) % 6'd3) == 6'd0);

    bcd_digit_feeder #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    bcd_digit_feeder #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic run_word(input logic [3:0] w0, input logic [3:0] w1,
                            input logic [3:0] w2, input logic [3:0] w3,
                            input int stall, input bit idles);
        logic [3:0] w [4];
        int  sum;
        int  g;
        bit  err;
        bit  dv;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        sum = int'(w0) + int'(w1) + int'(w2) + int'(w3);
        err = (w0 > 4'd9) || (w1 > 4'd9) || (w2 > 4'd9) || (w3 > 4'd9);
        dv  = !err && (sum % 3 == 0);
        if (dv) begin
            mdl_cnt8 = (mdl_cnt8 == 255) ? 255 : mdl_cnt8 + 1;
            mdl_cnt2 = (mdl_cnt2 == 3) ? 3 : mdl_cnt2 + 1;
        end

        for (int i = 0; i < 4; i++) begin
            if (idles) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid  = 1'b0;
                    in_nibble = 4'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid  = 1'b1;
            in_nibble = w[i];
            g = 0;
            while (bus8.in_ready !== 1'b1 && g < 20) begin
                @(posedge clk); #1;
                g++;
            end
            if (g == 20) begin
                checks++; failures++;
                $display("FAIL ready_timeout digit=%0d in_ready=%b required=1", i, bus8.in_ready);
            end
            @(posedge clk); #1;
        end

        // Junk offered while not ready must be ignored.
        in_valid  = 1'($urandom);
        in_nibble = 4'($urandom);
        checks++;
        if ({bus8.in_ready, bus8.res_valid} !== 2'b00) begin
            failures++;
            $display("FAIL eval_handshake ready_valid=%b required=00", {bus8.in_ready, bus8.res_valid});
        end

        @(posedge clk); #1;
        last_res_cyc = cyc;
        checks++;
        if ({bus8.in_ready, bus8.res_valid, bus8.res_div3, bus8.res_err} !== {1'b0, 1'b1, dv, err}) begin
            failures++;
            $display("FAIL result rdy_vld_div_err=%b required=%b",
                     {bus8.in_ready, bus8.res_valid, bus8.res_div3, bus8.res_err}, {1'b0, 1'b1, dv, err});
        end
        checks++;
        if ({bus8.a, bus8.b, bus8.c, bus8.d} !== {w0, w1, w2, w3}) begin
            failures++;
            $display("FAIL word_digits abcd=%h required=%h", {bus8.a, bus8.b, bus8.c, bus8.d}, {w0, w1, w2, w3});
        end
        checks++;
        if (bus8.match_count !== 8'(mdl_cnt8)) begin
            failures++;
            $display("FAIL count8 got=%0d required=%0d", bus8.match_count, mdl_cnt8);
        end
        checks++;
        if ({bus2.res_valid, bus2.res_div3, bus2.res_err, bus2.match_count} !== {1'b1, dv, err, 2'(mdl_cnt2)}) begin
            failures++;
            $display("FAIL narrow_result vld_div_err_cnt=%b required=%b",
                     {bus2.res_valid, bus2.res_div3, bus2.res_err, bus2.match_count}, {1'b1, dv, err, 2'(mdl_cnt2)});
        end

        for (int s = 0; s < stall; s++) begin
            res_ready = 1'b0;
            @(posedge clk); #1;
            checks++;
            if ({bus8.in_ready, bus8.res_valid, bus8.res_div3, bus8.res_err} !== {1'b0, 1'b1, dv, err}) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d rdy_vld_div_err=%b required=%b", s,
                         {bus8.in_ready, bus8.res_valid, bus8.res_div3, bus8.res_err}, {1'b0, 1'b1, dv, err});
            end
        end

        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if ({bus8.in_ready, bus8.res_valid} !== 2'b10) begin
            failures++;
            $display("FAIL release ready_valid=%b required=10", {bus8.in_ready, bus8.res_valid});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mdl_cnt8 = 0;
        mdl_cnt2 = 0;
        checks++;
        if ({bus8.in_ready, bus8.res_valid, bus8.res_div3, bus8.res_err} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags rdy_vld_div_err=%b required=1000",
                     {bus8.in_ready, bus8.res_valid, bus8.res_div3, bus8.res_err});
        end
        checks++;
        if ({bus8.a, bus8.b, bus8.c, bus8.d, bus8.match_count, bus2.match_count} !== 26'd0) begin
            failures++;
            $display("FAIL reset_data abcd=%h cnt8=%0d cnt2=%0d required=0",
                     {bus8.a, bus8.b, bus8.c, bus8.d}, bus8.match_count, bus2.match_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_word(4'd1, 4'd2, 4'd3, 4'd4, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first;
        run_word(4'd9, 4'd9, 4'd9, 4'd9, 0, 1'b0);
        first = last_res_cyc;
        run_word(4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0);
        checks++;
        if (last_res_cyc - first != 6) begin
            failures++;
            $display("FAIL throughput gap=%0d required=6", last_res_cyc - first);
        end
        checks++;
        if (bus8.match_count !== 8'd2) begin
            failures++;
            $display("FAIL two_matches count=%0d required=2", bus8.match_count);
        end
    endtask

    task automatic test_illegal_digit();
        force_div = 1'b1;
        run_word(4'd3, 4'hA, 4'd0, 4'd0, 0, 1'b0);
        force_div = 1'b0;
    endtask

    task automatic test_stall();
        run_word(4'd2, 4'd5, 4'd8, 4'd0, 5, 1'b0);
    endtask

    task automatic test_mid_reset();
        in_valid  = 1'b1;
        in_nibble = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_cnt8 = 0;
        mdl_cnt2 = 0;
        checks++;
        if ({bus8.in_ready, bus8.res_valid, bus8.a, bus8.b} !== 10'b10_0000_0000) begin
            failures++;
            $display("FAIL mid_reset rdy_vld=%b a=%h b=%h required ready=1 valid=0 a=b=0",
                     {bus8.in_ready, bus8.res_valid}, bus8.a, bus8.b);
        end
        run_word(4'd1, 4'd1, 4'd1, 4'd0, 0, 1'b0);
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin
            run_word(4'd3, 4'd0, 4'd0, 4'd0, 0, 1'b0);
        end
        checks++;
        if (bus2.match_count !== 2'd3) begin
            failures++;
            $display("FAIL saturate narrow_count=%0d required=3", bus2.match_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] w [4];
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++) begin
                w[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            run_word(w[0], w[1], w[2], w[3], int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal_digit();
        test_stall();
        test_mid_reset();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
